// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus: request/address out from the sequencer,
// ack/read data back from memory.
interface fetch_sequencer_if;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch and PC sequencer: fetches a word over the imem req/ack bus,
// holds it for decode/execute until retire, then steps pc by jump/branch outcome.
//
//  state | meaning
//  IDLE  | post-reset, one cycle before the first request
//  REQ   | imem req high at pc, waiting for ack (bounded by ACK_TIMEOUT)
//  RETRY | one request-free cycle after an ack timeout, same pc
//  HOLD  | instr valid and stable, waiting for retire
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          ACK_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master imem,
    output logic [15:0]       instr_o,
    output logic [3:0]        opcode_o,
    output logic              instr_valid_o,
    output logic [15:0]       pc_o,
    input  logic              retire_i,
    input  logic              jump_i,
    input  logic              beq_i,
    input  logic              bne_i,
    input  logic              zero_i,
    output logic [15:0]       retired_count_o,
    output logic              fetch_err_o
);
    localparam int                 CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RETRY, HOLD} state_t;

    state_t             state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic [15:0]        instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        count_q, count_d;
    logic               err_q, err_d;

    logic [15:0]        pc_plus2;
    logic [15:0]        br_off;
    logic [15:0]        br_target;
    logic [15:0]        next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            cnt_q   <= '0;
            count_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // beq, when asserted, decides on its own; bne is only looked at without beq.
    always_comb begin
        pc_plus2  = pc_q + 16'd2;
        br_off    = {{9{instr_q[5]}}, instr_q[5:0], 1'b0};
        br_target = pc_plus2 + br_off;
        if (jump_i)
            next_pc = {pc_plus2[15:13], instr_q[11:0], 1'b0};
        else if (beq_i)
            next_pc = zero_i ? br_target : pc_plus2;
        else if (bne_i && !zero_i)
            next_pc = br_target;
        else
            next_pc = pc_plus2;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                cnt_d   = '0;
            end
            REQ: begin
                if (imem.ack) begin
                    instr_d = imem.rdata;
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RETRY;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RETRY: begin
                state_d = REQ;
                cnt_d   = '0;
            end
            HOLD: begin
                if (retire_i) begin
                    pc_d    = next_pc;
                    count_d = count_q + 16'd1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem.req        = (state_q == REQ);
    assign imem.addr       = pc_q;
    assign instr_o         = instr_q;
    assign opcode_o        = instr_q[15:12];
    assign instr_valid_o   = (state_q == HOLD);
    assign pc_o            = pc_q;
    assign retired_count_o = count_q;
    assign fetch_err_o     = err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table of fetch/retire steps with a queue of
// expected fetch addresses, plus hand sequences for timeout, stall and reset.
module tb_fetch_sequencer;
    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam int          ACK_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        instr_valid;
    logic [15:0] pc;
    logic        retire = 1'b0;
    logic        jump = 1'b0;
    logic        beq = 1'b0;
    logic        bne = 1'b0;
    logic        zero = 1'b0;
    logic [15:0] retired_count;
    logic        fetch_err;

    fetch_sequencer_if imem ();

    fetch_sequencer #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem),
        .instr_o        (instr),
        .opcode_o       (opcode),
        .instr_valid_o  (instr_valid),
        .pc_o           (pc),
        .retire_i       (retire),
        .jump_i         (jump),
        .beq_i          (beq),
        .bne_i          (bne),
        .zero_i         (zero),
        .retired_count_o(retired_count),
        .fetch_err_o    (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        jump, beq, bne, zero;
        int          ack_dly;
        int          hold_dly;
        logic [15:0] exp_next;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_addr_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_count = 16'h0000;
    logic [15:0] cur_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [15:0] rdata, input logic j, input logic be, input logic bn,
                           input logic z, input int ad, input int hd, input logic [15:0] nxt);
        vec_t v;
        v.rdata = rdata; v.jump = j; v.beq = be; v.bne = bn; v.zero = z;
        v.ack_dly = ad; v.hold_dly = hd; v.exp_next = nxt;
        vecs.push_back(v);
    endtask

    task automatic wait_req(output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (imem.req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_req: imem_req not seen within 40 cycles");
        end
    endtask

    task automatic pop_addr(input string name);
        n_checks++;
        if (exp_addr_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: fetch at %h with empty scoreboard", name, imem.addr);
            cur_pc = imem.addr;
        end else begin
            cur_pc = exp_addr_q.pop_front();
            if (imem.addr !== cur_pc) begin
                n_fail++;
                $display("FAIL %s: imem_addr got %h expected %h", name, imem.addr, cur_pc);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic ok;
        wait_req(ok);
        if (!ok) return;
        pop_addr($sformatf("v%0d addr", idx));
        for (int d = 0; d < v.ack_dly; d++) begin
            @(negedge clk);
            chk($sformatf("v%0d req_held", idx), {31'd0, imem.req}, 32'd1);
        end
        imem.ack = 1'b1;
        imem.rdata = v.rdata;
        @(negedge clk);
        imem.ack = 1'b0;
        imem.rdata = 16'($urandom);
        chk($sformatf("v%0d valid", idx), {31'd0, instr_valid}, 32'd1);
        chk($sformatf("v%0d instr", idx), {16'd0, instr}, {16'd0, v.rdata});
        chk($sformatf("v%0d opcode", idx), {28'd0, opcode}, {28'd0, v.rdata[15:12]});
        chk($sformatf("v%0d pc", idx), {16'd0, pc}, {16'd0, cur_pc});
        chk($sformatf("v%0d req_low", idx), {31'd0, imem.req}, 32'd0);
        for (int d = 0; d < v.hold_dly; d++) @(negedge clk);
        retire = 1'b1; jump = v.jump; beq = v.beq; bne = v.bne; zero = v.zero;
        @(negedge clk);
        retire = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
        exp_count = exp_count + 16'd1;
        chk($sformatf("v%0d req_next", idx), {31'd0, imem.req}, 32'd1);
        chk($sformatf("v%0d count", idx), {16'd0, retired_count}, {16'd0, exp_count});
        exp_addr_q.push_back(v.exp_next);
    endtask

    initial begin
        logic ok;
        int   nreq;
        imem.ack = 1'b0;
        imem.rdata = 16'h0000;

        // Sequential fetch, branches (offset -2 at 0x0010), jump priority,
        // then a walk up through the 8K jump regions to the 0xFFFE wrap.
        add_vec(16'h2123, 0, 0, 0, 0, 0, 0, 16'h0002);
        add_vec(16'h2123, 0, 0, 0, 0, 1, 0, 16'h0004);
        add_vec(16'h2123, 0, 0, 0, 0, 0, 2, 16'h0006);
        add_vec(16'hF008, 1, 0, 0, 0, 2, 0, 16'h0010);
        add_vec(16'hA03E, 0, 1, 0, 1, 0, 1, 16'h000E);
        add_vec(16'hF008, 1, 0, 0, 0, 0, 0, 16'h0010);
        add_vec(16'hA03E, 0, 1, 0, 0, 3, 0, 16'h0012);
        add_vec(16'hF008, 1, 0, 0, 0, 0, 0, 16'h0010);
        add_vec(16'hA03E, 0, 0, 1, 0, 1, 1, 16'h000E);
        add_vec(16'hA03E, 0, 0, 1, 1, 0, 0, 16'h0010);
        add_vec(16'hA03E, 0, 1, 1, 1, 0, 0, 16'h000E);
        add_vec(16'hF008, 1, 1, 0, 1, 0, 0, 16'h0010);
        add_vec(16'hA005, 0, 1, 0, 1, 0, 0, 16'h001C);
        add_vec(16'hFFFF, 1, 0, 0, 0, 0, 0, 16'h1FFE);
        add_vec(16'hFFFF, 1, 0, 0, 0, 0, 0, 16'h3FFE);
        add_vec(16'h2123, 0, 0, 0, 0, 0, 0, 16'h4000);
        add_vec(16'hF123, 1, 0, 0, 0, 1, 0, 16'h4246);
        add_vec(16'hFFFF, 1, 0, 0, 0, 0, 0, 16'h5FFE);
        add_vec(16'hFFFF, 1, 0, 0, 0, 0, 0, 16'h7FFE);
        add_vec(16'hFFFF, 1, 0, 0, 0, 0, 0, 16'h9FFE);
        add_vec(16'hFFFF, 1, 0, 0, 0, 0, 0, 16'hBFFE);
        add_vec(16'hFFFF, 1, 0, 0, 0, 0, 0, 16'hDFFE);
        add_vec(16'hFFFF, 1, 0, 0, 0, 0, 0, 16'hFFFE);
        add_vec(16'h2123, 0, 0, 0, 0, 0, 0, 16'h0000);
        add_vec(16'hA03E, 0, 1, 0, 1, 0, 0, 16'hFFFE);
        add_vec(16'hF008, 1, 0, 0, 0, 0, 0, 16'h0010);

        // Reset values
        #1;
        chk("rst req", {31'd0, imem.req}, 32'd0);
        chk("rst addr", {16'd0, imem.addr}, {16'd0, RESET_PC});
        chk("rst instr", {16'd0, instr}, 32'd0);
        chk("rst valid", {31'd0, instr_valid}, 32'd0);
        chk("rst count", {16'd0, retired_count}, 32'd0);
        chk("rst err", {31'd0, fetch_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle req", {31'd0, imem.req}, 32'd0);
        @(negedge clk);
        chk("first req", {31'd0, imem.req}, 32'd1);
        exp_addr_q.push_back(RESET_PC);

        foreach (vecs[i]) begin
            run_vec(vecs[i], i);
            if (i == 2) chk("count after 3", {16'd0, retired_count}, 32'd3);
        end
        chk("no err yet", {31'd0, fetch_err}, 32'd0);

        // Retire pulsed in REQ is ignored
        wait_req(ok);
        pop_addr("outside addr");
        retire = 1'b1; jump = 1'b1;
        @(negedge clk);
        retire = 1'b0; jump = 1'b0;
        chk("outside req", {31'd0, imem.req}, 32'd1);
        chk("outside pc", {16'd0, pc}, {16'd0, cur_pc});
        chk("outside count", {16'd0, retired_count}, {16'd0, exp_count});

        // HOLD stall for 20 cycles, with a stray ack that must not be captured
        imem.ack = 1'b1; imem.rdata = 16'h1357;
        @(negedge clk);
        imem.ack = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin imem.ack = 1'b1; imem.rdata = 16'hBEEF; end
            if (c == 6) imem.ack = 1'b0;
            @(negedge clk);
            chk($sformatf("stall%0d", c),
                {instr_valid, imem.req, pc, instr[13:0]},
                {1'b1, 1'b0, cur_pc, 14'h1357});
        end
        retire = 1'b1;
        @(negedge clk);
        retire = 1'b0;
        exp_count = exp_count + 16'd1;
        exp_addr_q.push_back(16'h0012);

        // Ack timeout: 8 REQ cycles, 1 RETRY, REQ again at same pc
        wait_req(ok);
        pop_addr("to addr");
        nreq = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem.req !== 1'b1) break;
            nreq++;
        end
        chk("to req cycles", nreq, ACK_TIMEOUT);
        chk("to retry req", {31'd0, imem.req}, 32'd0);
        chk("to err", {31'd0, fetch_err}, 32'd1);
        chk("to retry addr", {16'd0, imem.addr}, {16'd0, cur_pc});
        imem.ack = 1'b1; imem.rdata = 16'hDEAD; retire = 1'b1;
        @(negedge clk);
        retire = 1'b0; imem.rdata = 16'h3456;
        chk("re-req", {31'd0, imem.req}, 32'd1);
        chk("re-req addr", {16'd0, imem.addr}, {16'd0, cur_pc});
        chk("retry count", {16'd0, retired_count}, {16'd0, exp_count});
        @(negedge clk);
        imem.ack = 1'b0;
        chk("to instr", {16'd0, instr}, 32'h3456);
        chk("to valid", {31'd0, instr_valid}, 32'd1);
        retire = 1'b1;
        @(negedge clk);
        retire = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("to count", {16'd0, retired_count}, {16'd0, exp_count});
        chk("err sticky", {31'd0, fetch_err}, 32'd1);
        chk("to next addr", {16'd0, imem.addr}, 32'h0014);

        // Reset mid-REQ with ack pending
        wait_req(ok);
        imem.ack = 1'b1; imem.rdata = 16'h2123;
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst req", {31'd0, imem.req}, 32'd0);
        chk("mid rst pc", {16'd0, pc}, {16'd0, RESET_PC});
        chk("mid rst valid", {31'd0, instr_valid}, 32'd0);
        chk("mid rst instr", {16'd0, instr}, 32'd0);
        chk("mid rst err", {31'd0, fetch_err}, 32'd0);
        chk("mid rst count", {16'd0, retired_count}, 32'd0);
        @(negedge clk);
        imem.ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr_q.delete();
        exp_addr_q.push_back(RESET_PC);
        exp_count = 16'h0000;
        run_vec(vecs[0], 100);
        wait_req(ok);
        pop_addr("post rst addr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and PC sequencing block for the 16-bit processor. It fetches 16-bit instruction words from instruction memory over a req/ack handshake and holds each word for the control unit and datapath. Once the datapath retires the instruction, it computes the next PC from the jump/beq/bne/zero outcome. It is the producer of the opcode stream that the control unit decodes, and the consumer of that decoder's branch/jump outputs.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset (must be even)
- ACK_TIMEOUT, 8, consecutive REQ cycles without ack before a retry (≥2)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request
- imem_addr  output  16  byte address of requested word (= pc)
- imem_ack  input  1  rdata valid this cycle, accepted at the edge
- imem_rdata  input  16  instruction word
- instr  output  16  held instruction
- opcode  output  4  instr[15:12], to control unit
- instr_valid  output  1  instr is live for decode/execute
- pc  output  16  address of held / requested instruction
- retire  input  1  held instruction finished this cycle; the branch inputs below are valid
- jump, beq, bne  input  1 each  control unit outputs for held instruction
- zero  input  1  ALU zero flag for held instruction
- retired_count  output  16  retired instruction counter, wraps
- fetch_err  output  1  sticky: at least one ack timeout occurred

## Operation
- States: IDLE, REQ, RETRY, HOLD.
- IDLE: entered on reset. Next cycle goes to REQ.
- REQ: imem_req=1, imem_addr=pc.
  - imem_ack=1: instr<=imem_rdata, go to HOLD.
  - No ack: timeout counter increments (cleared on entry to REQ). When the counter reaches ACK_TIMEOUT-1 with no ack, go to RETRY and set fetch_err.
- RETRY: imem_req=0 for exactly one cycle, then REQ at the same pc.
- HOLD: instr_valid=1, imem_req=0. Waits any number of cycles for retire.
  - On retire: pc<=next_pc, retired_count+1, go to REQ.
  - retire is ignored in every state other than HOLD.
- next_pc, with pc_plus2 = pc+2. Priority order:
  - jump: {pc_plus2[15:13], instr[11:0], 1'b0}
  - beq & zero: pc_plus2 + (sext(instr[5:0])<<1)
  - bne & !zero: pc_plus2 + (sext(instr[5:0])<<1)
  - otherwise: pc_plus2
- If beq and bne are both asserted, beq has priority.
- All PC arithmetic is modulo 2^16 and wraps silently (0xFFFE+2 = 0x0000).
- opcode is combinationally instr[15:12]. Downstream must qualify opcode with instr_valid, because 0000 decodes as LW.
- fetch_err clears only on reset.

## Timing
- Reset values (asynchronous): state=IDLE, pc=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0, imem_addr=RESET_PC, retired_count=0, fetch_err=0, timeout counter=0.
- After rst_n deasserts, the first edge moves IDLE→REQ, so imem_req rises 1 cycle after reset release.
- Ack in the first REQ cycle gives instr_valid=1 on the following cycle. Best-case throughput is 2 cycles per instruction (REQ, HOLD with retire).
- instr, pc and instr_valid are stable for the whole HOLD period.
- retire is sampled at the edge. The new pc is visible on imem_addr in the very next cycle, together with imem_req=1.
- Timeout: with no ack, REQ lasts ACK_TIMEOUT cycles, then 1 RETRY cycle, then REQ again. fetch_err rises on the cycle after the last REQ cycle.
- Ack arriving in RETRY or HOLD is ignored; rdata is not captured.
- rst_n asserted mid-fetch or mid-HOLD aborts immediately: all outputs return to their reset values with no further edge. A pending ack is discarded.

## Test plan
- Reset then sequential fetch: RESET_PC=0; ack every REQ returning 16'h2123; retire every HOLD → imem_addr sequence 0x0000, 0x0002, 0x0004; retired_count=3 after three retires; opcode=4'b0010.
- Taken/not-taken branches: at pc=0x0010, instr=16'hA03E (offset −2):
  - beq=1, zero=1, retire → next imem_addr 0x000E.
  - Same instruction with zero=0 → 0x0012.
  - bne=1, zero=0 → 0x000E.
- Jump and wrap: at pc=0x4000, jump=1, instr[11:0]=12'h123 → next addr 0x4246. At pc=0xFFFE, plain retire → next addr 0x0000.
- Timeout: ACK_TIMEOUT=8, ack withheld → imem_req high 8 cycles, low 1 cycle, high again at the same address; fetch_err=1 and stays 1; a later ack completes the fetch normally.
- Stall in HOLD: no retire for 20 cycles → instr_valid, instr and pc unchanged, imem_req=0. retire pulsed outside HOLD → pc and retired_count unchanged.
- Reset mid-operation: drop rst_n during REQ with ack=1 → imem_req=0, pc=RESET_PC, instr_valid=0 immediately. After release, fetching restarts from RESET_PC.
